// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution stripe sequencer.
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        SWAP,
        COMPUTE,
        WAIT_PF,
        DRAIN,
        DONE
    } state_e;

    // Number of valid window positions along one image edge.
    function automatic int out_dim(input int image_size, input int kernel_size);
        return image_size - kernel_size + 1;
    endfunction

endpackage

// File: rtl/conv_valid_pipe.sv
// Delay line carrying a valid bit and its payload; advances only when adv=1.
module conv_valid_pipe #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             empty
);

    logic [DEPTH-1:0] valid_q;
    logic [WIDTH-1:0] data_q [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
        end else if (adv) begin
            valid_q[0] <= in_valid;
            // Idle slots carry zeros so the coordinate outputs stay quiet.
            data_q[0]  <= in_valid ? in_data : '0;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];
    assign empty     = ~|valid_q;

endmodule

// File: rtl/conv_sequencer.sv
// Stripe sequencer for a KxK convolution over a ping/pong row buffer.
// Optional CONV_SEQ_PERF_EN adds busy-cycle and stall-cycle counters.
module conv_sequencer
    import conv_pkg::*;
#(
    parameter int IMAGE_SIZE  = 16,
    parameter int KERNEL_SIZE = 3,
    parameter int CONV_LAT    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic                          row_req,
    output logic [$clog2(IMAGE_SIZE)-1:0] row_addr,
    input  logic                          row_ack,
    output logic                          ping_wr_en,
    output logic                          pong_wr_en,
    output logic                          ping_rd_en,
    output logic                          pong_rd_en,
    output logic                          conv_en,
    output logic                          pipe_hold,
    output logic [$clog2(IMAGE_SIZE)-1:0] win_col,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(IMAGE_SIZE)-1:0] out_row,
    output logic [$clog2(IMAGE_SIZE)-1:0] out_col,
`ifdef CONV_SEQ_PERF_EN
    output logic [31:0]                   cycle_cnt,
    output logic [31:0]                   stall_cnt,
`endif
    output state_e                        dbg_state
);

    localparam int AW = $clog2(IMAGE_SIZE);
    localparam int OD = out_dim(IMAGE_SIZE, KERNEL_SIZE);
    localparam int KW = $clog2(KERNEL_SIZE + 1);
    localparam logic [AW-1:0] LAST_IDX = AW'(OD - 1);
    localparam logic [KW-1:0] K_LAST   = KW'(KERNEL_SIZE - 1);

    state_e          state, state_n;
    logic [AW-1:0]   stripe, stripe_n;
    logic [AW-1:0]   win_col_q, win_col_n;
    logic [KW-1:0]   k, k_n;
    logic            wr_bank, wr_bank_n;
    logic            rd_bank, rd_bank_n;
    logic            rd_live, rd_live_n;
    logic            pf_done, pf_done_n;
    logic            fill_req, pf_req, ack_ok, last_ack, stall, pipe_empty;
    logic [2*AW-1:0] pipe_data;

    // Handshake: row_req holds until row_ack; an ack with no request is dropped.
    assign fill_req = (state == FILL);
    assign pf_req   = ((state == COMPUTE) || (state == WAIT_PF)) && !pf_done;
    assign row_req  = fill_req | pf_req;
    assign row_addr = stripe + AW'(k) + AW'(pf_req);
    assign ack_ok   = row_req & row_ack;
    assign last_ack = ack_ok && (k == K_LAST);
    assign stall    = out_valid & ~out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            stripe    <= '0;
            win_col_q <= '0;
            k         <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            rd_live   <= 1'b0;
            pf_done   <= 1'b0;
        end else begin
            state     <= state_n;
            stripe    <= stripe_n;
            win_col_q <= win_col_n;
            k         <= k_n;
            wr_bank   <= wr_bank_n;
            rd_bank   <= rd_bank_n;
            rd_live   <= rd_live_n;
            pf_done   <= pf_done_n;
        end
    end

    always_comb begin
        state_n   = state;
        stripe_n  = stripe;
        win_col_n = win_col_q;
        k_n       = k;
        wr_bank_n = wr_bank;
        rd_bank_n = rd_bank;
        rd_live_n = rd_live;
        pf_done_n = pf_done;
        conv_en   = 1'b0;

        // Row loading runs independently of output stalls.
        if (ack_ok) begin
            k_n = last_ack ? '0 : k + KW'(1);
            if (last_ack && pf_req) pf_done_n = 1'b1;
        end

        case (state)
            IDLE: begin
                if (start) begin
                    state_n   = FILL;
                    stripe_n  = '0;
                    win_col_n = '0;
                    k_n       = '0;
                    wr_bank_n = 1'b0;
                    rd_live_n = 1'b0;
                end
            end
            FILL: begin
                if (last_ack) state_n = SWAP;
            end
            SWAP: begin
                rd_bank_n = wr_bank;
                wr_bank_n = ~wr_bank;
                rd_live_n = 1'b1;
                win_col_n = '0;
                k_n       = '0;
                pf_done_n = (stripe == LAST_IDX);
                state_n   = COMPUTE;
            end
            COMPUTE: begin
                if (!stall) begin
                    conv_en = 1'b1;
                    if (win_col_q == LAST_IDX) begin
                        win_col_n = '0;
                        if (stripe == LAST_IDX) begin
                            state_n = DRAIN;
                        end else if (pf_done || last_ack) begin
                            state_n  = SWAP;
                            stripe_n = stripe + AW'(1);
                        end else begin
                            state_n = WAIT_PF;
                        end
                    end else begin
                        win_col_n = win_col_q + AW'(1);
                    end
                end
            end
            WAIT_PF: begin
                if (pf_done || last_ack) begin
                    state_n  = SWAP;
                    stripe_n = stripe + AW'(1);
                end
            end
            DRAIN: begin
                if (pipe_empty) state_n = DONE;
            end
            DONE: begin
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign ping_wr_en = busy & ~wr_bank;
    assign pong_wr_en = busy & wr_bank;
    // No read bank exists until the first stripe has been swapped in.
    assign ping_rd_en = busy & rd_live & ~rd_bank;
    assign pong_rd_en = busy & rd_live & rd_bank;
    assign pipe_hold  = stall;
    assign win_col    = win_col_q;
    assign dbg_state  = state;

    conv_valid_pipe #(
        .DEPTH (CONV_LAT),
        .WIDTH (2 * AW)
    ) u_valid_pipe (
        .clk       (clk),
        .rst       (rst),
        .adv       (~stall),
        .in_valid  (conv_en),
        .in_data   ({stripe, win_col_q}),
        .out_valid (out_valid),
        .out_data  (pipe_data),
        .empty     (pipe_empty)
    );

    assign out_row = pipe_data[2*AW-1:AW];
    assign out_col = pipe_data[AW-1:0];

`ifdef CONV_SEQ_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_cnt <= '0;
            stall_cnt <= '0;
        end else if ((state == IDLE) && start) begin
            cycle_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (busy && (cycle_cnt != '1)) cycle_cnt <= cycle_cnt + 32'd1;
            if (((state == WAIT_PF) || stall) && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_conv_sequencer.sv
// Directed bench for conv_sequencer: row-major result model, row-address model, literal pins.
// Build with CONV_SEQ_PERF_EN defined to also check the performance counters.
module tb_conv_sequencer;
    import conv_pkg::*;

    localparam int IMAGE_SIZE  = 16;
    localparam int KERNEL_SIZE = 3;
    localparam int CONV_LAT    = 4;
    localparam int AW          = 4;
    localparam int OD          = IMAGE_SIZE - KERNEL_SIZE + 1;
    localparam int NRES        = OD * OD;

    logic          clk, rst, start, busy, done, row_req, row_ack;
    logic [AW-1:0] row_addr, win_col, out_row, out_col;
    logic          ping_wr_en, pong_wr_en, ping_rd_en, pong_rd_en;
    logic          conv_en, pipe_hold, out_valid, out_ready;
    state_e        dbg_state;
`ifdef CONV_SEQ_PERF_EN
    logic [31:0]   cycle_cnt, stall_cnt;
`endif

    conv_sequencer #(
        .IMAGE_SIZE  (IMAGE_SIZE),
        .KERNEL_SIZE (KERNEL_SIZE),
        .CONV_LAT    (CONV_LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .row_req    (row_req),
        .row_addr   (row_addr),
        .row_ack    (row_ack),
        .ping_wr_en (ping_wr_en),
        .pong_wr_en (pong_wr_en),
        .ping_rd_en (ping_rd_en),
        .pong_rd_en (pong_rd_en),
        .conv_en    (conv_en),
        .pipe_hold  (pipe_hold),
        .win_col    (win_col),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_row    (out_row),
        .out_col    (out_col),
`ifdef CONV_SEQ_PERF_EN
        .cycle_cnt  (cycle_cnt),
        .stall_cnt  (stall_cnt),
`endif
        .dbg_state  (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;
    logic [2*AW-1:0] exp_q[$];
    logic [AW-1:0]   row_q[$];

    int  ack_delay = 1;
    int  stall_at  = -1;
    int  stall_left = 0;
    bit  stall_started = 0;
    bit  spur_req = 0;
    bit  spur_fired = 0;
    int  cyc = 0;
    int  acc_cnt, done_cnt, hold_cnt, waitpf_cnt, busy_cnt, stallc_cnt;
    int  stripe_cnt, issue_cnt, ack_cnt, waitpf_first;
    int  last_fill_cyc, first_conv_cyc, first_valid_cyc;
    logic [2*AW-1:0] first_res, last_res, held_res;
    state_e prev_state = IDLE;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic build_model();
        exp_q.delete();
        row_q.delete();
        for (int r = 0; r < OD; r++)
            for (int c = 0; c < OD; c++)
                exp_q.push_back({AW'(r), AW'(c)});
        for (int j = 0; j < KERNEL_SIZE; j++) row_q.push_back(AW'(j));
        for (int s = 0; s < OD - 1; s++)
            for (int j = 1; j <= KERNEL_SIZE; j++) row_q.push_back(AW'(s + j));
        acc_cnt = 0; done_cnt = 0; hold_cnt = 0; waitpf_cnt = 0; busy_cnt = 0;
        stallc_cnt = 0; stripe_cnt = 0; issue_cnt = 0; ack_cnt = 0; waitpf_first = -1;
        last_fill_cyc = -1; first_conv_cyc = -1; first_valid_cyc = -1;
        first_res = '1; last_res = '1; held_res = '1;
        stall_started = 0; stall_left = 0;
    endtask

    // ---------------- row_ack driver ----------------
    int ack_wait = 0;
    always @(negedge clk) begin
        if (!rst) begin
            row_ack  = 1'b0;
            ack_wait = 0;
        end else if (row_ack) begin
            row_ack  = 1'b0;
            ack_wait = 0;
        end else if (spur_req && !row_req) begin
            row_ack    = 1'b1;
            spur_req   = 0;
            spur_fired = 1;
        end else if (row_req) begin
            ack_wait++;
            if (ack_wait > ack_delay) row_ack = 1'b1;
        end
    end

    // ---------------- monitor / compare ----------------
    always @(negedge clk) begin
        cyc++;
        if (stall_at >= 0 && !stall_started && out_valid && acc_cnt == stall_at) begin
            stall_started = 1;
            stall_left    = 10;
            held_res      = {out_row, out_col};
        end
        if (stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
        end else begin
            out_ready = 1'b1;
        end
        #1;
        if (rst) begin
            if ((ping_wr_en & pong_wr_en) || (ping_rd_en & pong_rd_en) ||
                (ping_wr_en & ping_rd_en) || (pong_wr_en & pong_rd_en))
                check("bank_exclusive", {ping_wr_en, pong_wr_en, ping_rd_en, pong_rd_en}, 0);
            if (conv_en && pipe_hold) check("conv_en_during_hold", 1, 0);
            if (out_valid && !out_ready) check("hold_when_not_ready", pipe_hold, 1);
            if (conv_en) begin
                check("win_col", win_col, issue_cnt % OD);
                if (first_conv_cyc < 0) first_conv_cyc = cyc;
                issue_cnt++;
            end
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_result", {out_row, out_col}, -1);
                end else begin
                    check("result_coord", {out_row, out_col}, exp_q.pop_front());
                end
                if (acc_cnt == 0) first_res = {out_row, out_col};
                last_res = {out_row, out_col};
                acc_cnt++;
            end
            if (row_req && row_ack) begin
                if (row_q.size() == 0) check("extra_row_ack", row_addr, -1);
                else check("row_addr", row_addr, row_q.pop_front());
                ack_cnt++;
                if (ack_cnt == KERNEL_SIZE) last_fill_cyc = cyc;
            end
            if (dbg_state == COMPUTE && prev_state == SWAP) begin
                check("rd_bank_ping", ping_rd_en, (stripe_cnt % 2 == 0));
                check("rd_bank_pong", pong_rd_en, (stripe_cnt % 2 == 1));
                stripe_cnt++;
            end
            if (dbg_state == WAIT_PF) begin
                waitpf_cnt++;
                if (waitpf_first < 0) waitpf_first = stripe_cnt;
            end
            if (pipe_hold) hold_cnt++;
            if (busy) busy_cnt++;
            if (busy && (pipe_hold || dbg_state == WAIT_PF)) stallc_cnt++;
            if (done) done_cnt++;
            prev_state = dbg_state;
        end else begin
            prev_state = IDLE;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_all_zero(input string name);
        check(name, {busy, done, row_req, row_addr, ping_wr_en, pong_wr_en, ping_rd_en,
                     pong_rd_en, conv_en, pipe_hold, win_col, out_valid, out_row, out_col}, 0);
    endtask

    task automatic run_pass(input int delay, input int stall_idx, input int rst_idx, input bit inject);
        int n;
        bit hit;
        build_model();
        ack_delay = delay;
        stall_at  = stall_idx;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (inject) begin
            hit = 0;
            for (n = 0; n < 2000 && !hit; n++) begin
                @(negedge clk); #2;
                if (dbg_state == COMPUTE) hit = 1;
            end
            check("inject_reach_compute", hit, 1);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            hit = 0;
            for (n = 0; n < 2000 && !hit; n++) begin
                @(negedge clk); #2;
                if (dbg_state == COMPUTE && !row_req) hit = 1;
            end
            spur_fired = 0;
            spur_req   = 1;
            repeat (4) @(negedge clk);
            check("spurious_ack_fired", spur_fired, 1);
        end
        if (rst_idx >= 0) begin
            hit = 0;
            for (n = 0; n < 20000 && !hit; n++) begin
                @(negedge clk); #2;
                if (acc_cnt == rst_idx) hit = 1;
            end
            check("reach_reset_point", hit, 1);
            rst = 1'b0;
            #1;
            check_all_zero("outputs_in_midpass_reset");
            repeat (3) @(negedge clk);
            check("no_done_after_reset", done_cnt, 0);
            check("results_before_reset", acc_cnt, rst_idx);
            rst = 1'b1;
        end else begin
            hit = 0;
            for (n = 0; n < 20000 && !hit; n++) begin
                @(negedge clk); #2;
                if (done_cnt > 0) hit = 1;
            end
            check("pass_done_seen", hit, 1);
            repeat (8) @(negedge clk);
            #2;
            check("result_count", acc_cnt, NRES);
            check("model_drained", exp_q.size(), 0);
            check("rows_drained", row_q.size(), 0);
            check("done_pulses", done_cnt, 1);
            check("stripes", stripe_cnt, OD);
            check("idle_after_pass", busy, 0);
            check("last_result_13_13", last_res, 8'hDD);
        end
        stall_at = -1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b0; start = 1'b0; out_ready = 1'b1; row_ack = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("outputs_in_reset");
        rst = 1'b1;
        @(negedge clk);

        // Defaults, prompt acks, always ready.
        run_pass(1, -1, -1, 0);
        check("first_result_0_0", first_res, 0);
        check("swap_to_first_issue", first_conv_cyc - last_fill_cyc, 2);
        check("issue_to_first_valid", first_valid_cyc - first_conv_cyc, CONV_LAT);
        check("no_hold_when_ready", hold_cnt, 0);

        // Slow row source forces WAIT_PF from stripe 0.
        run_pass(20, -1, -1, 0);
        check("wait_pf_on_stripe0", waitpf_first, 1);
        check("wait_pf_seen", waitpf_cnt > 0, 1);

        // Ten-cycle downstream stall inside stripe 5 (result index 76 = (5,6)).
        run_pass(1, 76, -1, 0);
        check("held_coord_5_6", held_res, 8'h56);
        check("hold_cycles", hold_cnt, 10);
`ifdef CONV_SEQ_PERF_EN
        check("perf_stall_cnt", stall_cnt, 10 + waitpf_cnt);
        check("perf_cycle_cnt", cycle_cnt, busy_cnt);
        check("perf_stall_model", stallc_cnt, 10 + waitpf_cnt);
`endif

        // Reset at result 57, then a clean pass.
        run_pass(1, -1, 57, 0);
        run_pass(1, -1, -1, 0);
        check("first_after_reset_0_0", first_res, 0);

        // Start while busy and a stray row_ack are both ignored.
        run_pass(1, -1, -1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_sequencer.md
CONV_SEQUENCER -- requirements
Module: conv_sequencer

Interface
REQ-001 SHALL have parameter IMAGE_SIZE, default 16: image width and height in pixels.
REQ-002 SHALL have parameter KERNEL_SIZE, default 3: kernel edge, and the number of rows in one stripe.
REQ-003 SHALL have parameter CONV_LAT, default 4: cycles from conv_en to the corresponding conv result.
REQ-004 SHALL have ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  pulse that begins one image pass.
- busy  out  1  pass in progress.
- done  out  1  one-cycle pulse at the end of a pass.
- row_req  out  1  request one image row into the write bank.
- row_addr  out  $clog2(IMAGE_SIZE)  image row being requested.
- row_ack  in  1  requested row written; one-cycle pulse.
- ping_wr_en, pong_wr_en  out  1 each  write-bank select.
- ping_rd_en, pong_rd_en  out  1 each  read-bank select.
- conv_en  out  1  window issued to the conv datapath this cycle.
- pipe_hold  out  1  datapath freezes its pipeline registers.
- win_col  out  $clog2(IMAGE_SIZE)  left column of the issued window.
- out_valid  out  1  conv result valid.
- out_ready  in  1  downstream accepts the result.
- out_row, out_col  out  $clog2(IMAGE_SIZE) each  coordinates of the result.

Function
REQ-005 SHALL define OUT_DIM = IMAGE_SIZE-KERNEL_SIZE+1; one pass SHALL produce exactly OUT_DIM*OUT_DIM results (196 at the defaults), in row-major order.
REQ-006 SHALL implement the states IDLE, FILL, SWAP, COMPUTE, WAIT_PF, DRAIN and DONE.
REQ-007 IDLE: busy=0; start=1 SHALL go to FILL with stripe=0 and the write bank set to ping.
REQ-008 FILL: row_req SHALL stay high with row_addr=stripe+k for k=0..KERNEL_SIZE-1; each row_ack SHALL advance k; after the last ack the FSM SHALL go to SWAP.
REQ-009 SWAP SHALL last one cycle: it SHALL toggle the read bank to the bank just filled, make the write bank the other one, then go to COMPUTE.
REQ-010 COMPUTE SHALL assert conv_en each unstalled cycle with win_col stepping 0..OUT_DIM-1.
REQ-011 While in COMPUTE and stripe<OUT_DIM-1, the FSM SHALL prefetch rows stripe+1..stripe+KERNEL_SIZE into the write bank using the REQ-008 handshake.
REQ-012 After win_col=OUT_DIM-1 is issued:
- prefetch complete -> SWAP, then stripe+1;
- prefetch pending -> WAIT_PF (conv_en=0) until the last row_ack, then SWAP;
- last stripe -> DRAIN.
REQ-013 The FSM SHALL keep a CONV_LAT-deep valid shift register fed by conv_en; its output drives out_valid, and out_row/out_col SHALL travel alongside it.
REQ-014 Stall: when out_valid=1 and out_ready=0, pipe_hold=1, conv_en=0, and the shift register and column counter SHALL hold; the row handshake SHALL continue.
REQ-015 DRAIN SHALL wait until the shift register is empty, then go to DONE; DONE SHALL pulse done for one cycle, then go to IDLE.
REQ-016 start while busy=1 SHALL be ignored.
REQ-017 row_ack while row_req=0 SHALL be ignored.
REQ-018 At most one of ping_wr_en and pong_wr_en, and at most one of ping_rd_en and pong_rd_en, SHALL be high in any cycle; the read bank SHALL never equal the write bank while busy.

Reset
REQ-019 On rst=0, asynchronously:
- FSM state SHALL be IDLE; stripe, k and win_col SHALL be 0; the bank select SHALL be ping.
- The shift register SHALL be cleared.
- Every output SHALL be 0.
REQ-020 Reset mid-pass SHALL abandon the pass with no done pulse; the first result after the next start SHALL be (0,0).

Configuration
REQ-021 With CONV_SEQ_PERF_EN defined, the block SHALL add outputs cycle_cnt[31:0] (cycles with busy=1) and stall_cnt[31:0] (cycles in WAIT_PF or with pipe_hold=1). Both SHALL clear on start and saturate at all-ones.
REQ-022 With CONV_SEQ_PERF_EN undefined, those ports and counters SHALL not exist and behaviour SHALL otherwise be identical.

Structure
REQ-023 The state enum and the OUT_DIM function SHALL live in the shared package conv_pkg.
REQ-024 The valid/coordinate delay line SHALL be a sub-module conv_valid_pipe, parameterised by depth and payload width.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Defaults; row_ack 1 cycle after every row_req; out_ready=1 -> 196 results (0,0)..(13,13) in order; first out_valid 3 (FILL) + 1 (SWAP) + CONV_LAT cycles after the last FILL ack window; done once.
- row_ack delayed 20 cycles -> WAIT_PF entered on stripe 0; zero results lost or duplicated; ping/pong read selects alternate per stripe.
- out_ready=0 for 10 cycles mid-stripe 5 -> pipe_hold=1 for exactly those cycles; no conv_en; sequence resumes at the held coordinate.
- rst=0 asserted at result 57 -> all outputs 0 immediately; a new start yields (0,0) first and 196 results in total.
- start pulsed during COMPUTE, plus a spurious row_ack while row_req=0 -> no effect; result count still 196.
- CONV_SEQ_PERF_EN defined with the stall scenario -> stall_cnt=10 plus the WAIT_PF cycles, and cycle_cnt equals the busy-high cycle count.
